// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and helpers for the PE-array partial-sum writeback path.
//   state_e     : writeback FSM states
//   KSIZE_3/5   : the legal kernel sizes
//   sat_to_out  : clamp a signed value into an out_w-bit signed range
package cnn_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACCUM = 3'd1,
      SKIP  = 3'd2,
      DRAIN = 3'd3,
      FIN   = 3'd4
   } state_e;

   localparam logic [2:0] KSIZE_3 = 3'd3;
   localparam logic [2:0] KSIZE_5 = 3'd5;

   // Result stays 32 bits wide; the caller keeps the low out_w bits.
   function automatic logic signed [31:0] sat_to_out(input logic signed [31:0] v,
                                                     input int               out_w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      logic signed [31:0] res;
      hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) begin
         res = hi;
      end else if (v < lo) begin
         res = lo;
      end else begin
         res = v;
      end
      return res;
   endfunction

endpackage

// File: rtl/psum_line_buf.sv
// psum_line_buf: MAX_W x ACC_W line buffer holding per-column running sums.
// Ports:
//   clk_i          clock
//   rd_addr_i      read-port column
//   rd_data_o      read-port data (combinational)
//   rmw_en_i       commit the read-modify-write result
//   rmw_addr_i     read-modify-write column
//   rmw_init_i     1: overwrite with rmw_val_i, 0: add rmw_val_i to stored value
//   rmw_val_i      sign-extended partial to write/accumulate
//   rmw_result_o   value that will be written (used for read-after-write forwarding)
// Contents are not reset; every column is overwritten by the first row of a band.
module psum_line_buf #(
   parameter int MAX_W = 32,
   parameter int ACC_W = 20,
   parameter int AW    = 5
) (
   input  logic                    clk_i,
   input  logic [AW-1:0]           rd_addr_i,
   output logic signed [ACC_W-1:0] rd_data_o,
   input  logic                    rmw_en_i,
   input  logic [AW-1:0]           rmw_addr_i,
   input  logic                    rmw_init_i,
   input  logic signed [ACC_W-1:0] rmw_val_i,
   output logic signed [ACC_W-1:0] rmw_result_o
);

   logic signed [ACC_W-1:0] mem_q [MAX_W];

   assign rd_data_o    = mem_q[rd_addr_i];
   assign rmw_result_o = rmw_init_i ? rmw_val_i : (mem_q[rmw_addr_i] + rmw_val_i);

   always_ff @(posedge clk_i) begin
      if (rmw_en_i) begin
         mem_q[rmw_addr_i] <= rmw_result_o;
      end
   end

endmodule

// File: rtl/psum_writeback.sv
// psum_writeback: consumer of the PE-array partial-sum stream. Accumulates K
// row-partials per output column, saturates, stride-decimates and writes the
// output feature map to memory, then pulses DONE.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load, kernel_size,         frame start and configuration (IDLE only)
//   width_size, stride
//   psum_valid/_data/_ready    incoming row-partial stream
//   out_valid/_data/_addr/     registered output word stream
//   out_ready
//   busy                       frame in progress
//   cfg_err                    sticky illegal-configuration flag
//   DONE                       one-cycle frame-complete pulse
// Build option: define PSUM_WB_RELU_EN to clamp negative results to 0 after
// saturation.
//
// state | meaning
// IDLE  | waiting for load
// ACCUM | accepting row-partials into the line buffer
// SKIP  | discard a full row that stride 2 decimates away
// DRAIN | write one output row, column step S, honouring out_ready
// FIN   | DONE pulse
module psum_writeback
   import cnn_pkg::*;
#(
   parameter int PSUM_W = 16,
   parameter int ACC_W  = 20,
   parameter int OUT_W  = 16,
   parameter int MAX_W  = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [2:0]        kernel_size,
   input  logic [4:0]        width_size,
   input  logic              stride,
   input  logic              psum_valid,
   input  logic [PSUM_W-1:0] psum_data,
   output logic              psum_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              out_ready,
   output logic              busy,
   output logic              cfg_err,
   output logic              DONE
);

   localparam int CW = 5;

   state_e state_q, state_d;

   logic [2:0]        k_q, k_d;
   logic [CW-1:0]     n_q, n_d;
   logic              s2_q, s2_d;
   logic [2:0]        r_q, r_d;
   logic [CW-1:0]     c_q, c_d;
   logic [CW-1:0]     frow_q, frow_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              cfg_err_q, cfg_err_d;

   logic              cfg_legal;
   logic [CW-1:0]     n_new;
   logic              xfer;
   logic              row_end;
   logic              last_r;
   logic              acc_done;
   logic              keep_row;
   logic              frow_last;
   logic              drain_last;
   logic [CW:0]       step;
   logic [CW:0]       c_next;

   logic [CW-1:0]           rd_addr;
   logic signed [ACC_W-1:0] rd_data;
   logic signed [ACC_W-1:0] rmw_val;
   logic signed [ACC_W-1:0] rmw_result;
   logic signed [ACC_W-1:0] fwd;
   logic signed [31:0]      fwd32;
   logic [OUT_W-1:0]        out_word;

   assign cfg_legal = ((kernel_size == KSIZE_3) || (kernel_size == KSIZE_5)) &&
                      (width_size >= {2'b00, kernel_size});
   assign n_new     = width_size - {2'b00, kernel_size} + 5'd1;

   assign xfer       = (state_q == ACCUM) && psum_valid;
   assign row_end    = (c_q == n_q - 5'd1);
   assign last_r     = (r_q == k_q - 3'd1);
   assign acc_done   = xfer && row_end && last_r;
   assign keep_row   = !s2_q || !frow_q[0];
   assign frow_last  = (frow_q == n_q - 5'd1);
   assign step       = {{CW{1'b0}}, 1'b1} + {{CW{1'b0}}, s2_q};
   assign c_next     = {1'b0, c_q} + step;
   assign drain_last = (c_next >= {1'b0, n_q});

   // In DRAIN the read port prefetches the next column to present; when a band
   // completes it fetches column 0, which may be the very entry being written
   // this cycle (N = 1), hence the forward from the RMW port.
   assign rd_addr  = (state_q == DRAIN) ? c_next[CW-1:0] : '0;
   assign rmw_val  = {{(ACC_W-PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
   assign fwd      = (xfer && (c_q == '0)) ? rmw_result : rd_data;
   assign fwd32    = {{(32-ACC_W){fwd[ACC_W-1]}}, fwd};

   always_comb begin
      out_word = OUT_W'(sat_to_out(fwd32, OUT_W));
`ifdef PSUM_WB_RELU_EN
      if (out_word[OUT_W-1]) begin
         out_word = '0;
      end
`endif
   end

   psum_line_buf #(
      .MAX_W(MAX_W),
      .ACC_W(ACC_W),
      .AW   (CW)
   ) u_line_buf (
      .clk_i       (clk),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data),
      .rmw_en_i    (xfer),
      .rmw_addr_i  (c_q),
      .rmw_init_i  (r_q == 3'd0),
      .rmw_val_i   (rmw_val),
      .rmw_result_o(rmw_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load && cfg_legal) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (acc_done) begin
               state_d = keep_row ? DRAIN : SKIP;
            end
         end
         SKIP: begin
            state_d = frow_last ? FIN : ACCUM;
         end
         DRAIN: begin
            if (out_ready && drain_last) begin
               state_d = frow_last ? FIN : ACCUM;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      psum_ready = (state_q == ACCUM);
      busy       = (state_q != IDLE);
      DONE       = (state_q == FIN);
   end

   always_comb begin
      k_d         = k_q;
      n_d         = n_q;
      s2_d        = s2_q;
      r_d         = r_q;
      c_d         = c_q;
      frow_d      = frow_q;
      wcnt_d      = wcnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      cfg_err_d   = cfg_err_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               if (cfg_legal) begin
                  cfg_err_d = 1'b0;
                  k_d       = kernel_size;
                  n_d       = n_new;
                  s2_d      = stride;
                  r_d       = '0;
                  c_d       = '0;
                  frow_d    = '0;
                  wcnt_d    = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (xfer) begin
               if (row_end) begin
                  c_d = '0;
                  if (last_r) begin
                     r_d = '0;
                     if (keep_row) begin
                        out_valid_d = 1'b1;
                        out_data_d  = out_word;
                        out_addr_d  = wcnt_q;
                     end
                  end else begin
                     r_d = r_q + 3'd1;
                  end
               end else begin
                  c_d = c_q + 5'd1;
               end
            end
         end
         SKIP: begin
            frow_d = frow_q + 5'd1;
            r_d    = '0;
            c_d    = '0;
         end
         DRAIN: begin
            if (out_ready) begin
               wcnt_d = wcnt_q + 1'b1;
               if (drain_last) begin
                  out_valid_d = 1'b0;
                  c_d         = '0;
                  r_d         = '0;
                  frow_d      = frow_q + 5'd1;
               end else begin
                  c_d        = c_next[CW-1:0];
                  out_data_d = out_word;
                  out_addr_d = wcnt_q + 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q         <= '0;
         n_q         <= '0;
         s2_q        <= 1'b0;
         r_q         <= '0;
         c_q         <= '0;
         frow_q      <= '0;
         wcnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         k_q         <= k_d;
         n_q         <= n_d;
         s2_q        <= s2_d;
         r_q         <= r_d;
         c_q         <= c_d;
         frow_q      <= frow_d;
         wcnt_q      <= wcnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_psum_writeback.sv
module tb_psum_writeback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [2:0]  kernel_size = 3'd3;
   logic [4:0]  width_size = 5'd5;
   logic        stride = 1'b0;
   logic        psum_valid = 1'b0;
   logic [15:0] psum_data = '0;
   logic        psum_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic [9:0]  out_addr;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        cfg_err;
   logic        DONE;

   always #5 clk = ~clk;

   psum_writeback dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .kernel_size(kernel_size),
      .width_size (width_size),
      .stride     (stride),
      .psum_valid (psum_valid),
      .psum_data  (psum_data),
      .psum_ready (psum_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_addr   (out_addr),
      .out_ready  (out_ready),
      .busy       (busy),
      .cfg_err    (cfg_err),
      .DONE       (DONE)
   );

   // w,k,s: config; mode 0 = constant val, 1 = partial equals its column index;
   // bp: out_ready toggles; np: partials; nw: words; ow: words per output row;
   // e0..e2: expected word for output column 0..2.
   typedef struct {
      int w; int k; int s; int mode; int val; int bp;
      int np; int nw; int ow; int e0; int e1; int e2;
   } vec_t;

   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic sv(input int i, input int w, input int k, input int s, input int mode,
                     input int val, input int bp, input int np, input int nw, input int ow,
                     input int e0, input int e1, input int e2);
      vecs[i].w = w;   vecs[i].k = k;   vecs[i].s = s;   vecs[i].mode = mode;
      vecs[i].val = val; vecs[i].bp = bp; vecs[i].np = np; vecs[i].nw = nw;
      vecs[i].ow = ow; vecs[i].e0 = e0; vecs[i].e1 = e1; vecs[i].e2 = e2;
   endtask

   // Called at posedge+1; returns at posedge+1 after the load edge.
   task automatic do_load(input int k, input int w, input int s);
      kernel_size = 3'(k);
      width_size  = 5'(w);
      stride      = s[0];
      load        = 1'b1;
      @(posedge clk); #1;
      load        = 1'b0;
   endtask

   task automatic run_frame(input int vi);
      vec_t        v;
      int          n, kn, acc, words, dones, cyc, tail, expd;
      bit          exp_ov, prev_stall;
      logic [15:0] prev_data;
      logic [9:0]  prev_addr;
      v = vecs[vi];
      n = v.w - v.k + 1;
      kn = v.k * n;
      acc = 0; words = 0; dones = 0; cyc = 0; tail = -1;
      exp_ov = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_addr = '0;
      do_load(v.k, v.w, v.s);
      while (cyc < 3000 && tail != 0) begin
         psum_valid = (acc < v.np);
         psum_data  = (v.mode == 0) ? 16'(v.val) : 16'((acc % kn) % n);
         out_ready  = (v.bp != 0) ? ((cyc % 2) == 0) : 1'b1;
         // load while busy, with an illegal config, must be ignored
         load        = (cyc == 4);
         kernel_size = (cyc == 4) ? 3'd4 : 3'(v.k);
         width_size  = (cyc == 4) ? 5'd2 : 5'(v.w);
         @(negedge clk);
         if (cyc == 0) begin
            check("busy_after_load", int'(busy), 1);
            check("cfg_err_after_load", int'(cfg_err), 0);
         end
         if (exp_ov) begin
            check("first_out_latency", int'(out_valid), 1);
            exp_ov = 1'b0;
         end
         if (out_valid) check("psum_ready_in_drain", int'(psum_ready), 0);
         if (prev_stall) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), int'(prev_data));
            check("stall_addr", int'(out_addr), int'(prev_addr));
         end
         if (out_valid && out_ready) begin
            case (words % v.ow)
               0: expd = v.e0;
               1: expd = v.e1;
               default: expd = v.e2;
            endcase
            check("out_data", int'(out_data), expd);
            check("out_addr", int'(out_addr), words);
            words++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_addr  = out_addr;
         if (psum_valid && psum_ready) begin
            if (((acc + 1) % kn) == 0 && ((acc / kn) % (v.s + 1)) == 0) exp_ov = 1'b1;
            acc++;
         end
         if (DONE) dones++;
         if (DONE && tail < 0) tail = 2;
         else if (tail > 0) tail--;
         cyc++;
         @(posedge clk); #1;
      end
      psum_valid  = 1'b0;
      out_ready   = 1'b0;
      load        = 1'b0;
      kernel_size = 3'(v.k);
      width_size  = 5'(v.w);
      check("frame_timeout", tail, 0);
      check("partials_accepted", acc, v.np);
      check("words_written", words, v.nw);
      check("done_pulses", dones, 1);
      check("busy_after_frame", int'(busy), 0);
      check("cfg_err_after_frame", int'(cfg_err), 0);
   endtask

   initial begin
      int neg8000;
      int waitc;
`ifdef PSUM_WB_RELU_EN
      neg8000 = 0;
`else
      neg8000 = 'h8000;
`endif
      sv(0, 5, 3, 0, 0, 1,       0, 27, 9, 3, 3, 3, 3);
      sv(1, 7, 3, 1, 1, 0,       0, 75, 9, 3, 0, 6, 12);
      sv(2, 5, 3, 0, 0, 1,       1, 27, 9, 3, 3, 3, 3);
      sv(3, 3, 3, 0, 0, 'h7FFF,  0, 3,  1, 1, 'h7FFF, 0, 0);
      sv(4, 3, 3, 0, 0, 'h8000,  0, 3,  1, 1, neg8000, 0, 0);
      sv(5, 5, 5, 0, 0, 2,       1, 5,  1, 1, 'hA, 0, 0);
      sv(6, 6, 3, 1, 1, 0,       0, 48, 4, 2, 0, 6, 0);

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_psum_ready", int'(psum_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_addr", int'(out_addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      check("rst_done", int'(DONE), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // psum_valid in IDLE is not consumed
      psum_valid = 1'b1;
      psum_data  = 16'h0001;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_psum_ready", int'(psum_ready), 0);
      check("idle_busy", int'(busy), 0);
      @(posedge clk); #1;
      psum_valid = 1'b0;

      // illegal configurations
      do_load(4, 5, 0);
      @(negedge clk);
      check("cfg_err_k4", int'(cfg_err), 1);
      check("busy_k4", int'(busy), 0);
      check("no_write_k4", int'(out_valid), 0);
      @(posedge clk); #1;
      do_load(3, 2, 0);
      @(negedge clk);
      check("cfg_err_w2", int'(cfg_err), 1);
      check("busy_w2", int'(busy), 0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_frame(i);
      end

      // asynchronous reset during DRAIN
      do_load(3, 5, 0);
      psum_valid = 1'b1;
      psum_data  = 16'h0001;
      out_ready  = 1'b0;
      waitc = 0;
      @(negedge clk);
      while (!out_valid && waitc < 200) begin
         waitc++;
         @(negedge clk);
      end
      check("reach_drain", int'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_psum_ready", int'(psum_ready), 0);
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_out_data", int'(out_data), 0);
      check("arst_out_addr", int'(out_addr), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_cfg_err", int'(cfg_err), 0);
      check("arst_done", int'(DONE), 0);
      psum_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
